ahb_rr_master: RTL and testbench
================================

Name: ahb_rr_master

Overview:
- Two-requester AHB-Lite master that shares one AHB slave port (the word-addressed RAM slave) between two local requesters.
- Each requester issues single 32-bit word transfers over a level req / pulse ack handshake.
- The block arbitrates round-robin, sequences the AHB address and data phases, honours slave wait states and error responses, and returns read data per requester.
- It sits between two local engines (e.g. CPU-side shim and a DMA engine) and the RAM slave's HSEL/HTRANS/HADDR inputs.

Parameters:
- AW, 5, address width; matches the slave's address width.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  asynchronous active-high reset
- req0  in  1  requester 0 transfer request (level)
- addr0  in  AW  requester 0 byte address; bits [1:0] ignored
- write0  in  1  requester 0: 1=write, 0=read
- wdata0  in  32  requester 0 write data
- ack0  out  1  one-cycle completion pulse to requester 0
- err0  out  1  error flag; valid only with ack0
- rdata0  out  32  read data; valid with ack0, held until next ack0
- req1, addr1, write1, wdata1, ack1, err1, rdata1: same as requester 0, for requester 1
- HSEL  out  1  slave select
- HTRANS  out  2  transfer type; 2'b00 IDLE, 2'b10 NONSEQ only
- HADDR  out  AW  word-aligned address
- HWRITE  out  1  write control
- HSIZE  out  3  constant 3'b010 (word)
- HWDATA  out  32  write data, driven in data phase
- HREADY  in  1  slave HREADYOUT; single master, so this is also the bus HREADY
- HRESP  in  1  slave response
- HRDATA  in  32  slave read data

Behaviour:
- Reset values (asynchronous on HRESET=1):
  - state=IDLE, HSEL=0, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0
  - ack0=ack1=0, err0=err1=0, rdata0=rdata1=0
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Eligible requester: reqN=1 and ackN=0 in the same cycle. This blocks re-issue while a requester is still seeing its ack.
  - No eligible requester: stay in IDLE.
  - Exactly one eligible: grant it.
  - Both eligible: grant the requester other than last_grant.
  - On grant: latch {addr[AW-1:2],2'b00}, write, wdata into hold registers; update last_grant; go to ADDR.
- ADDR:
  - Drive HSEL=1, HTRANS=10, HADDR and HWRITE from the hold registers.
  - If HREADY=1, go to DATA; otherwise stay in ADDR.
- DATA:
  - Drive HSEL=0, HTRANS=00; HWDATA=hold wdata, held stable for the whole phase.
  - If HREADY=0, stay in DATA. Wait states are unbounded; there is no timeout.
  - If HREADY=1: at the next edge pulse ack of the granted requester for 1 cycle; err=HRESP; if the transfer was a read, rdataN<=HRDATA; return to IDLE.
- Two-cycle error (HRESP=1, HREADY=0, then HRESP=1, HREADY=1):
  - The block waits for the second cycle, then completes with err=1.
  - No cancel and no retry.
- Latency: request seen in IDLE at cycle 0 → address phase at cycle 1 → data phase at cycle 2 → ack at cycle 3, with zero wait states. Throughput is one transfer per 4 cycles.
- Handshake rules:
  - Requester holds req, addr, write and wdata stable until ack.
  - A req still high in the cycle after ack is a new transfer.
  - Inputs of a requester that is not granted are ignored.
- HSIZE is tied to 3'b010. Sub-word transfers are not supported.
- HRESET asserted mid-transfer: outputs return to reset values immediately; no ack or err for the aborted transfer; a pending request re-arbitrates after reset is released.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HSIZE_WORD=3'b010
  - state enum {IDLE, ADDR, DATA}
- Sub-module rr_arb2: two-way round-robin picker with last_grant register.
  - Inputs: HCLK, HRESET, eligible[1:0], update
  - Outputs: grant[1:0] (one-hot), grant_id

Test Plan:
- Write then read: req0 write addr 0x04 data 0xDEADBEEF → HTRANS=10, HADDR=0x04, HWRITE=1 in cycle 1; HWDATA=0xDEADBEEF in cycle 2; ack0 in cycle 3, err0=0. Then a req0 read of 0x04 → rdata0=0xDEADBEEF with ack0.
- Contention: req0=req1=1 from reset, both held high → grants 0,1,0,1; each ack followed by its own next transfer; no starvation.
- Wait states: slave holds HREADY=0 for 3 cycles in DATA → HWDATA stable for all 4 data cycles; ack0 at cycle 6.
- Error: HRESP=1/HREADY=0, then HRESP=1/HREADY=1 on a req1 read → ack1=1, err1=1 in the same cycle; next transfer completes with err1=0.
- Alignment and re-issue: addr0=0x07 → HADDR=0x04. req0 held high through ack0 → a second transfer starts in the cycle after ack0, never in the ack0 cycle.
- Reset mid-op: HRESET pulsed during DATA → HTRANS=00, HSEL=0, ack0=0 immediately; no ack ever for the aborted transfer.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_e;

  // One-hot grant vector for a two-way picker.
  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; a tie goes to the requester that did not win last.
module rr_arb2
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [1:0] eligible,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_grant_q, last_grant_d;

  // pick a winner among the eligible requesters
  always_comb begin
    grant_id = eligible[1];
    if (eligible == 2'b11) begin
      grant_id = ~last_grant_q;
    end
    grant = (eligible == 2'b00) ? 2'b00 : onehot2(grant_id);
  end

  // remember the winner only when a grant is actually taken
  always_comb begin
    last_grant_d = last_grant_q;
    if (update && (|eligible)) begin
      last_grant_d = grant_id;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ahb_rr_master.sv
// Two local requesters sharing one AHB-Lite slave port, single word transfers.
//
// state | meaning
// IDLE  | arbitrate; winner's request is latched into the hold registers
// ADDR  | address phase on the bus, held until HREADY
// DATA  | data phase, HWDATA from hold; completion on HREADY pulses ack
module ahb_rr_master
  import ahb_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          write0,
  input  logic [31:0]   wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [31:0]   rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          write1,
  input  logic [31:0]   wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [31:0]   rdata1,
  output logic          HSEL,
  output logic [1:0]    HTRANS,
  output logic [AW-1:0] HADDR,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [31:0]   HRDATA
);

  state_e        state_q, state_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic          gid_q, gid_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]    eligible;
  logic [1:0]    grant;
  logic          grant_id;
  logic          unused_addr_lsb;

  // a requester still seeing its ack may not re-issue in that cycle
  assign eligible = {req1 & ~ack1_q, req0 & ~ack0_q};
  assign unused_addr_lsb = ^{addr0[1:0], addr1[1:0]};

  rr_arb2 u_arb (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .eligible (eligible),
    .update   (state_q == IDLE),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant) state_d = ADDR;
      ADDR:    if (HREADY) state_d = DATA;
      DATA:    if (HREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus control outputs decoded from state
  always_comb begin
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    if (state_q == ADDR) begin
      HSEL   = 1'b1;
      HTRANS = HTRANS_NONSEQ;
    end
  end

  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HWDATA = hwdata_q;
  assign HSIZE  = HSIZE_WORD;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

  // hold registers on grant, requester responses on data-phase completion
  always_comb begin
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    gid_d    = gid_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if ((state_q == IDLE) && (|grant)) begin
      gid_d = grant_id;
      if (grant[1]) begin
        haddr_d  = {addr1[AW-1:2], 2'b00};
        hwrite_d = write1;
        hwdata_d = wdata1;
      end else begin
        haddr_d  = {addr0[AW-1:2], 2'b00};
        hwrite_d = write0;
        hwdata_d = wdata0;
      end
    end
    if ((state_q == DATA) && HREADY) begin
      if (gid_q) begin
        ack1_d = 1'b1;
        err1_d = HRESP;
        if (!hwrite_q) rdata1_d = HRDATA;
      end else begin
        ack0_d = 1'b1;
        err0_d = HRESP;
        if (!hwrite_q) rdata0_d = HRDATA;
      end
    end
  end

  // datapath and response flops
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      gid_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      gid_q    <= gid_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_ahb_rr_master.sv
// Bench for ahb_rr_master: RAM slave model with wait states and two-cycle
// errors, per-requester expectation queues, directed timing cases, then
// two independent random requesters.
module tb_ahb_rr_master;
  localparam int AW = 5;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          write0 = 1'b0, write1 = 1'b0;
  logic [31:0]   wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1;
  logic [31:0]   rdata0, rdata1;
  logic          HSEL, HWRITE, HREADY, HRESP;
  logic [1:0]    HTRANS;
  logic [AW-1:0] HADDR;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA, HRDATA;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_rr_master #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0(req0), .addr0(addr0), .write0(write0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .write1(write1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // words 3 and 7 are unmapped in the slave and always answer with an error
  function automatic logic err_word(input logic [2:0] w);
    return (w[1:0] == 2'b11);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + i;
  endfunction

  // ---------------- slave model ----------------
  logic [31:0] mem [8];
  logic        dp_active, dp_write, dp_err;
  logic [2:0]  dp_word;
  int          wait_left;
  int          fixed_waits = 0;

  assign HREADY = !dp_active || (wait_left == 0);
  assign HRESP  = dp_active && dp_err && (wait_left <= 1);
  assign HRDATA = (dp_active && !dp_write) ? mem[dp_word] : 32'h0;

  always @(posedge HCLK or posedge HRESET) begin : slave
    int nw;
    if (HRESET) begin
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_err    <= 1'b0;
      dp_word   <= '0;
      wait_left <= 0;
      for (int i = 0; i < 8; i++) mem[i] <= init_word(i);
    end else begin
      if (dp_active) begin
        if (wait_left == 0) begin
          if (dp_write && !dp_err) mem[dp_word] <= HWDATA;
          dp_active <= 1'b0;
        end else begin
          wait_left <= wait_left - 1;
        end
      end
      if (HSEL && HTRANS == 2'b10 && HREADY) begin
        nw = (fixed_waits >= 0) ? fixed_waits : int'($urandom_range(0, 3));
        if (err_word(HADDR[4:2]) && nw < 1) nw = 1;
        dp_active <= 1'b1;
        dp_word   <= HADDR[4:2];
        dp_write  <= HWRITE;
        dp_err    <= err_word(HADDR[4:2]);
        wait_left <= nw;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic [31:0]   model_mem [8];
  exp_t          exp_q0[$];
  exp_t          exp_q1[$];
  logic          cur_valid [2];
  logic [AW-1:0] cur_addr  [2];
  logic          cur_write [2];
  logic [31:0]   cur_wdata [2];

  task automatic model_init();
    for (int i = 0; i < 8; i++) model_mem[i] = init_word(i);
  endtask

  // present a request; requester 0 owns words 0-3, requester 1 words 4-7
  task automatic issue(input int id, input logic [AW-1:0] a, input logic wr, input logic [31:0] wd);
    exp_t e;
    logic [2:0] w;
    w      = a[4:2];
    e.err  = err_word(w);
    e.rd   = !wr;
    e.data = model_mem[w];
    if (wr && !e.err) model_mem[w] = wd;
    cur_valid[id] = 1'b1;
    cur_addr[id]  = a;
    cur_write[id] = wr;
    cur_wdata[id] = wd;
    if (id == 0) begin
      exp_q0.push_back(e);
      req0 = 1'b1; addr0 = a; write0 = wr; wdata0 = wd;
    end else begin
      exp_q1.push_back(e);
      req1 = 1'b1; addr1 = a; write1 = wr; wdata1 = wd;
    end
  endtask

  task automatic drop(input int id);
    cur_valid[id] = 1'b0;
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr(input int id);
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15));
    a[4] = (id == 1);
    return a;
  endfunction

  // waits at falling edges until the requester's ack, bounded
  task automatic wait_ack(input int id, input int budget, output int cyc);
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge HCLK);
      cyc++;
      seen = (id == 0) ? ack0 : ack1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout%0d: no ack after %0d cycles, expected ack", id, budget);
    end
  endtask

  task automatic check_ack(input int id, input logic e, input logic [31:0] rd);
    exp_t x;
    if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ack%0d: ack seen, expected no ack", id);
      return;
    end
    if (id == 0) x = exp_q0.pop_front();
    else         x = exp_q1.pop_front();
    chk($sformatf("err%0d", id), 32'(e), 32'(x.err));
    if (x.rd) chk($sformatf("rdata%0d", id), rd, x.data);
  endtask

  // monitor: bus phases against the pending request, acks against the queues
  always @(posedge HCLK) begin : mon
    int g;
    #1;
    if (!HRESET) begin
      if (HSEL && HTRANS == 2'b10) begin
        g = int'(HADDR[4]);
        chk("addr_owner_pending", 32'(cur_valid[g]), 32'd1);
        chk("haddr_aligned", 32'(HADDR), 32'({cur_addr[g][AW-1:2], 2'b00}));
        chk("hwrite", 32'(HWRITE), 32'(cur_write[g]));
      end
      if (dp_active && dp_write) chk("hwdata_data_phase", HWDATA, cur_wdata[int'(dp_word[2])]);
      if (ack0) check_ack(0, err0, rdata0);
      if (ack1) check_ack(1, err1, rdata1);
    end
  end

  task automatic do_reset();
    HRESET = 1'b1;
    drop(0);
    drop(1);
    exp_q0.delete();
    exp_q1.delete();
    model_init();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic single(input int id);
    int c;
    @(negedge HCLK);
    issue(id, rnd_addr(id), 1'($urandom_range(0, 1)), $urandom);
    wait_ack(id, 50, c);
    drop(id);
  endtask

  // both request in the same cycle; report which is served first
  task automatic both_first(output int first);
    int c;
    logic got0, got1;
    first = -1;
    got0 = 1'b0;
    got1 = 1'b0;
    c = 0;
    @(negedge HCLK);
    issue(0, rnd_addr(0), 1'($urandom_range(0, 1)), $urandom);
    issue(1, rnd_addr(1), 1'($urandom_range(0, 1)), $urandom);
    while (!(got0 && got1) && c < 50) begin
      @(negedge HCLK);
      c++;
      if (ack0) begin if (first < 0) first = 0; got0 = 1'b1; drop(0); end
      if (ack1) begin if (first < 0) first = 1; got1 = 1'b1; drop(1); end
    end
    chk("both_served", 32'({got0, got1}), 32'b11);
  endtask

  task automatic rand_driver(input int id);
    int c;
    @(negedge HCLK);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        drop(id);
        repeat ($urandom_range(1, 4)) @(negedge HCLK);
      end
      issue(id, rnd_addr(id), 1'($urandom_range(0, 1)), $urandom);
      wait_ack(id, 200, c);
    end
    drop(id);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin : main
    int cyc, first, nacks, budget;
    int order [8];
    logic [31:0] wd;

    do_reset();
    chk("rst_hsel", 32'(HSEL), 32'd0);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", 32'(HADDR), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd2);
    chk("rst_acks", 32'({ack0, ack1, err0, err1}), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);

    // write then read, zero wait states
    fixed_waits = 0;
    @(negedge HCLK);
    issue(0, 5'h04, 1'b1, 32'hDEADBEEF);
    @(negedge HCLK);
    chk("wr_c1_hsel", 32'(HSEL), 32'd1);
    chk("wr_c1_htrans", 32'(HTRANS), 32'd2);
    chk("wr_c1_haddr", 32'(HADDR), 32'h04);
    chk("wr_c1_hwrite", 32'(HWRITE), 32'd1);
    @(negedge HCLK);
    chk("wr_c2_hwdata", HWDATA, 32'hDEADBEEF);
    chk("wr_c2_htrans", 32'(HTRANS), 32'd0);
    chk("wr_c2_no_ack", 32'(ack0), 32'd0);
    @(negedge HCLK);
    chk("wr_c3_ack0", 32'(ack0), 32'd1);
    chk("wr_c3_err0", 32'(err0), 32'd0);
    drop(0);
    @(negedge HCLK);
    issue(0, 5'h04, 1'b0, 32'h0);
    wait_ack(0, 20, cyc);
    chk("rd_latency", 32'(cyc), 32'd3);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    drop(0);

    // three wait states in the data phase
    @(negedge HCLK);
    fixed_waits = 3;
    wd = $urandom;
    issue(0, 5'h08, 1'b1, wd);
    @(negedge HCLK);
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("ws_hwdata_stable", HWDATA, wd);
      chk("ws_no_early_ack", 32'(ack0), 32'd0);
    end
    @(negedge HCLK);
    chk("ws_ack0_cycle6", 32'(ack0), 32'd1);
    drop(0);
    fixed_waits = 0;

    // two-cycle error response on a requester 1 read, then a clean read
    @(negedge HCLK);
    issue(1, 5'h1C, 1'b0, 32'h0);
    wait_ack(1, 20, cyc);
    chk("err_ack1_cycle", 32'(cyc), 32'd4);
    chk("err_err1_with_ack", 32'(err1), 32'd1);
    drop(1);
    @(negedge HCLK);
    issue(1, 5'h10, 1'b0, 32'h0);
    wait_ack(1, 20, cyc);
    chk("err_clear_err1", 32'(err1), 32'd0);
    drop(1);

    // alignment, then req held high through ack
    @(negedge HCLK);
    issue(0, 5'h07, 1'b0, 32'h0);
    @(negedge HCLK);
    chk("align_haddr", 32'(HADDR), 32'h04);
    wait_ack(0, 20, cyc);
    issue(0, 5'h0B, 1'b0, 32'h0);
    chk("reissue_ack_cycle_idle", 32'(HTRANS), 32'd0);
    @(negedge HCLK);
    chk("reissue_next_cycle_idle", 32'(HTRANS), 32'd0);
    @(negedge HCLK);
    chk("reissue_addr_phase", 32'(HTRANS), 32'd2);
    chk("reissue_haddr", 32'(HADDR), 32'h08);
    wait_ack(0, 20, cyc);
    drop(0);

    // contention from reset with both requests held high
    do_reset();
    issue(0, rnd_addr(0), 1'($urandom_range(0, 1)), $urandom);
    issue(1, rnd_addr(1), 1'($urandom_range(0, 1)), $urandom);
    nacks = 0;
    budget = 0;
    while (nacks < 7 && budget < 200) begin
      @(negedge HCLK);
      budget++;
      if (ack0 && nacks < 8) begin
        order[nacks] = 0;
        nacks++;
        if (nacks < 6) issue(0, rnd_addr(0), 1'($urandom_range(0, 1)), $urandom);
        else drop(0);
      end
      if (ack1 && nacks < 8) begin
        order[nacks] = 1;
        nacks++;
        if (nacks < 6) issue(1, rnd_addr(1), 1'($urandom_range(0, 1)), $urandom);
        else drop(1);
      end
    end
    chk("cont_ack_count", 32'(nacks), 32'd7);
    for (int i = 0; i < 7 && i < nacks; i++) chk($sformatf("cont_order%0d", i), 32'(order[i]), 32'(i % 2));

    // ties after a lone grant go to the other requester
    single(0);
    both_first(first);
    chk("rr_tie_after_req0", 32'(first), 32'd1);
    single(1);
    both_first(first);
    chk("rr_tie_after_req1", 32'(first), 32'd0);

    // reset in the data phase with the request still pending
    @(negedge HCLK);
    fixed_waits = 2;
    issue(0, 5'h08, 1'b0, 32'hA5A5_0001);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    chk("midrst_hsel", 32'(HSEL), 32'd0);
    chk("midrst_htrans", 32'(HTRANS), 32'd0);
    chk("midrst_hwdata", HWDATA, 32'd0);
    chk("midrst_haddr", 32'(HADDR), 32'd0);
    chk("midrst_ack0", 32'(ack0), 32'd0);
    exp_q0.delete();
    model_init();
    fixed_waits = 0;
    @(negedge HCLK);
    issue(0, 5'h08, 1'b0, 32'hA5A5_0001);
    @(negedge HCLK);
    HRESET = 1'b0;
    wait_ack(0, 20, cyc);
    chk("midrst_rearb_latency", 32'(cyc), 32'd3);
    chk("midrst_rdata0", rdata0, init_word(2));
    drop(0);
    repeat (5) begin
      @(negedge HCLK);
      chk("midrst_no_extra_ack", 32'(ack0), 32'd0);
    end

    // two independent random requesters with random wait states
    fixed_waits = -1;
    fork
      rand_driver(0);
      rand_driver(1);
    join
    repeat (10) @(negedge HCLK);
    chk("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
